pipe_stage_elastic: RTL and testbench

- Parametrised, elastic pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle, with valid/ready handshake on both sides.
- A 2-entry skid buffer provides full throughput under back-pressure.
- Synchronous flush inserts bubbles; control bits of any non-valid output are forced to zero.

---
 rtl/pipe_stage_elastic.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: a head entry plus a skid entry sustain one beat per
// cycle under back-pressure, and a flush turns every held entry into a zero-control bubble.
module pipe_stage_elastic #(
   parameter int CTRL_W     = 8,
   parameter int DATA_W     = 155,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   occ_e              occ_q, occ_d;
   logic              in_ready_q, in_ready_d;
   logic              h_valid_q, h_valid_d;
   logic [CTRL_W-1:0] h_ctrl_q, h_ctrl_d;
   logic [DATA_W-1:0] h_data_q, h_data_d;
   logic              s_valid_q, s_valid_d;
   logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
   logic [DATA_W-1:0] s_data_q, s_data_d;

   logic accept;
   logic drain;

   // in_ready is a flop, so accepting never waits on downstream's out_ready.
   assign accept = in_valid && in_ready_q;
   assign drain  = h_valid_q && out_ready;

   always_comb begin
      // NOTE: every _d starts from its _q; a path that forgets an assignment would infer a latch.
      occ_d      = occ_q;
      in_ready_d = in_ready_q;
      h_valid_d  = h_valid_q;
      h_ctrl_d   = h_ctrl_q;
      h_data_d   = h_data_q;
      s_valid_d  = s_valid_q;
      s_ctrl_d   = s_ctrl_q;
      s_data_d   = s_data_q;

      if (flush) begin
         // The incoming beat and the head are both killed; neither counts as transferred.
         occ_d     = EMPTY;
         h_valid_d = 1'b0;
         h_ctrl_d  = '0;
         s_valid_d = 1'b0;
         s_ctrl_d  = '0;
         if (CLEAR_DATA) begin
            h_data_d = '0;
            s_data_d = '0;
         end
      end else begin
         case (occ_q)
            EMPTY: begin
               if (accept) begin
                  h_valid_d = 1'b1;
                  h_ctrl_d  = in_ctrl;
                  h_data_d  = in_data;
                  occ_d     = ONE;
               end
            end
            ONE: begin
               if (accept && !drain) begin
                  s_valid_d = 1'b1;
                  s_ctrl_d  = in_ctrl;
                  s_data_d  = in_data;
                  occ_d     = FULL;
               end else if (accept && drain) begin
                  h_ctrl_d = in_ctrl;
                  h_data_d = in_data;
               end else if (drain) begin
                  h_valid_d = 1'b0;
                  h_ctrl_d  = '0;
                  occ_d     = EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  h_ctrl_d  = s_ctrl_q;
                  h_data_d  = s_data_q;
                  s_valid_d = 1'b0;
                  s_ctrl_d  = '0;
                  if (CLEAR_DATA) begin
                     s_data_d = '0;
                  end
                  occ_d = ONE;
               end
            end
            default: begin
               occ_d = occ_q;
            end
         endcase
      end

      in_ready_d = (occ_d != FULL);
   end

   always_ff @(posedge clk) begin
      // NOTE: data entries are reset as well, because out_data must read zero out of reset.
      if (!reset) begin
         occ_q      <= EMPTY;
         in_ready_q <= 1'b0;
         h_valid_q  <= 1'b0;
         h_ctrl_q   <= '0;
         h_data_q   <= '0;
         s_valid_q  <= 1'b0;
         s_ctrl_q   <= '0;
         s_data_q   <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         occ_q      <= occ_d;
         in_ready_q <= in_ready_d;
         h_valid_q  <= h_valid_d;
         h_ctrl_q   <= h_ctrl_d;
         h_data_q   <= h_data_d;
         s_valid_q  <= s_valid_d;
         s_ctrl_q   <= s_ctrl_d;
         s_data_q   <= s_data_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = h_valid_q;
   assign out_ctrl  = h_ctrl_q & {CTRL_W{h_valid_q}};
   assign out_data  = h_data_q;
   assign occupancy = occ_q;

   // Structural invariants tying the occupancy count to the entry valid bits.
   a_skid_implies_head: assert property (@(posedge clk) disable iff (!reset)
      s_valid_q |-> h_valid_q);
   a_occ_matches_valid: assert property (@(posedge clk) disable iff (!reset)
      occupancy == ({1'b0, h_valid_q} + {1'b0, s_valid_q}));
   a_full_not_ready: assert property (@(posedge clk) disable iff (!reset)
      (occ_q == FULL) |-> !in_ready_q);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: two instances (data cleared / data held) share stimulus and
// are checked against a queue-based reference of the beats each stage should be holding.
module tb_pipe_stage_elastic;

   localparam int CTRL_W = 8;
   localparam int DATA_W = 155;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;

   logic              c_in_ready, c_out_valid;
   logic [CTRL_W-1:0] c_out_ctrl;
   logic [DATA_W-1:0] c_out_data;
   logic [1:0]        c_occupancy;
   logic              h_in_ready, h_out_valid;
   logic [CTRL_W-1:0] h_out_ctrl;
   logic [DATA_W-1:0] h_out_data;
   logic [1:0]        h_occupancy;

   int total = 0;
   int bad   = 0;

   // Reference: beats currently held by the stage, oldest first, plus expected in_ready.
   beat_t             exp_q[$];
   logic              exp_ready = 1'b0;
   logic              idle_c_ok = 1'b1;
   logic              idle_h_ok = 1'b1;
   logic [DATA_W-1:0] idle_c    = '0;
   logic [DATA_W-1:0] idle_h    = '0;

   always #5 clk = ~clk;

   pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b1)) dut_c (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
      .out_ctrl(c_out_ctrl), .out_data(c_out_data), .flush(flush), .occupancy(c_occupancy)
   );

   pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b0)) dut_h (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(h_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(h_out_valid), .out_ready(out_ready),
      .out_ctrl(h_out_ctrl), .out_data(h_out_data), .flush(flush), .occupancy(h_occupancy)
   );

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares what both stages present against the head of the reference queue,
   // then retires the head when the coming edge drains it.
   always @(negedge clk) begin
      beat_t hd;
      logic  has;
      has = (exp_q.size() > 0);
      hd  = has ? exp_q[0] : '0;
      check("c_out_valid", 160'(c_out_valid), 160'(has));
      check("h_out_valid", 160'(h_out_valid), 160'(has));
      check("c_out_ctrl", 160'(c_out_ctrl), 160'(hd.ctrl));
      check("h_out_ctrl", 160'(h_out_ctrl), 160'(hd.ctrl));
      check("c_occupancy", 160'(c_occupancy), 160'(exp_q.size()));
      check("h_occupancy", 160'(h_occupancy), 160'(exp_q.size()));
      check("c_in_ready", 160'(c_in_ready), 160'(exp_ready));
      check("h_in_ready", 160'(h_in_ready), 160'(exp_ready));
      if (has) begin
         check("c_out_data", 160'(c_out_data), 160'(hd.data));
         check("h_out_data", 160'(h_out_data), 160'(hd.data));
      end else begin
         if (idle_c_ok) check("c_idle_data", 160'(c_out_data), 160'(idle_c));
         if (idle_h_ok) check("h_idle_data", 160'(h_out_data), 160'(idle_h));
      end
      if (reset && !flush && has && out_ready) void'(exp_q.pop_front());
   end

   // Scoreboard feed: records each beat the stage should accept at the coming edge, and
   // applies reset/flush to the reference after the monitor has retired any drained head.
   always @(negedge clk) begin
      #1;
      if (!reset) begin
         exp_q.delete();
         exp_ready = 1'b0;
         idle_c_ok = 1'b1;
         idle_h_ok = 1'b1;
         idle_c    = '0;
         idle_h    = '0;
      end else if (flush) begin
         idle_c_ok = 1'b1;
         idle_c    = '0;
         idle_h_ok = (exp_q.size() > 0);
         if (exp_q.size() > 0) idle_h = exp_q[0].data;
         exp_q.delete();
         exp_ready = 1'b1;
      end else begin
         if (in_valid && exp_ready) begin
            exp_q.push_back('{ctrl: in_ctrl, data: in_data});
            idle_c_ok = 1'b0;
            idle_h_ok = 1'b0;
         end
         exp_ready = (exp_q.size() != 2);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Presents one beat and holds it until the stage takes it (bounded wait).
   task automatic send(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
      in_valid = 1'b1;
      in_ctrl  = c;
      in_data  = d;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (c_in_ready === 1'b1 && !flush) begin
            tick(1);
            in_valid = 1'b0;
            return;
         end
         tick(1);
      end
      check("send_timeout", 160'(0), 160'(1));
      in_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_ctrl   = '0;
      in_data   = '0;
      tick(2);

      // Release reset and offer the first beat straight away.
      reset     = 1'b1;
      out_ready = 1'b1;
      send(8'hA5, DATA_W'(1));

      for (int i = 1; i <= 8; i++) send(8'(8'h10 + i), DATA_W'(i));
      tick(3);

      // Stall: two beats fill the stage, the third waits upstream.
      out_ready = 1'b0;
      send(8'h0A, DATA_W'(10));
      send(8'h0B, DATA_W'(11));
      in_valid = 1'b1;
      in_ctrl  = 8'h0C;
      in_data  = DATA_W'(12);
      tick(3);
      out_ready = 1'b1;
      send(8'h0C, DATA_W'(12));
      tick(4);

      // Flush while full, with a competing input beat and all-ones control on the bus.
      out_ready = 1'b0;
      send(8'h14, DATA_W'(20));
      send(8'h15, DATA_W'(21));
      in_valid = 1'b1;
      in_ctrl  = 8'hFF;
      in_data  = DATA_W'(22);
      flush    = 1'b1;
      tick(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      tick(3);
      out_ready = 1'b1;
      send(8'h17, DATA_W'(23));
      tick(3);

      // Reset while full: held beats must never reappear.
      out_ready = 1'b0;
      send(8'h1E, DATA_W'(30));
      send(8'h1F, DATA_W'(31));
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(2);
      out_ready = 1'b1;
      tick(3);
      send(8'h20, DATA_W'(32));
      tick(3);

      // Random traffic with alternating back-pressure phases, sparse flushes and resets.
      for (int n = 0; n < 2000; n++) begin
         reset     = ($urandom_range(99) != 0);
         flush     = ($urandom_range(15) == 0);
         in_valid  = 1'($urandom_range(1));
         out_ready = ($urandom_range(99) < (((n / 250) % 2 == 1) ? 30 : 85));
         in_ctrl   = 8'($urandom);
         in_data   = DATA_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
         tick(1);
      end

      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
